spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop count on sclk/ss/mosi (legal range 2-3).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port CPOL  input  1  sclk idle level; static while ss is low.
REQ-005 SHALL have port CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; static while ss is low.
REQ-006 SHALL have port sclk  input  1  serial clock from master, asynchronous to clk.
REQ-007 SHALL have port ss  input  1  active-low slave select, asynchronous.
REQ-008 SHALL have port mosi  input  1  serial data in, MSB first.
REQ-009 SHALL have port miso  output  1  serial data out, MSB first.
REQ-010 SHALL have port miso_oe  output  1  miso drive enable for the pad tristate.
REQ-011 SHALL have port datain  input  8  next byte to transmit, sampled on tx_load.
REQ-012 SHALL have port tx_load  output  1  one-clk pulse: datain captured; user may change datain afterwards.
REQ-013 SHALL have port dataout  output  8  last complete received byte.
REQ-014 SHALL have port rx_valid  output  1  one-clk pulse: dataout updated.
REQ-015 SHALL have port aborted  output  1  one-clk pulse: ss deasserted with a partial byte.
REQ-016 SHALL have port busy  output  1  high while the synchronized ss is low.

Function
REQ-017 SHALL pass sclk, ss and mosi through SYNC_STAGES flops, then one edge-detect flop; detected edges lag pins by SYNC_STAGES+1 clk.
REQ-018 SHALL define leading edge as sclk leaving CPOL and trailing edge as sclk returning to CPOL; sample edge = leading if CPHA=0 else trailing; drive edge = the other.
REQ-019 SHALL implement FSM IDLE -> ACTIVE on synchronized ss falling, ACTIVE -> IDLE on synchronized ss rising; sclk edges ignored in IDLE.
REQ-020 SHALL keep a 3-bit bit_cnt, cleared on IDLE->ACTIVE, incremented per sample edge, wrapping 7->0.
REQ-021 SHALL shift synchronized mosi into rx shift register LSB on each sample edge.
REQ-022 SHALL, on the sample edge where bit_cnt wraps 7->0, write the full byte to dataout and pulse rx_valid in the following clk.
REQ-023 SHALL drive miso = tx_reg[7] while miso_oe=1, else 0; miso_oe = 1 in ACTIVE only.
REQ-024 SHALL, on a drive edge with bit_cnt=0, load tx_reg from datain and pulse tx_load; on any other drive edge shift tx_reg left, filling 0.
REQ-025 SHALL, when CPHA=0, additionally load tx_reg from datain and pulse tx_load on IDLE->ACTIVE so bit 7 is valid before the first leading edge.
REQ-026 SHALL support back-to-back bytes in one ss frame without gaps; each byte gets one tx_load and one rx_valid.
REQ-027 SHALL, on ACTIVE->IDLE with bit_cnt!=0, pulse aborted, suppress rx_valid, discard the partial byte and leave dataout unchanged.
REQ-028 SHALL, if ss deasserts on the same clk a sample edge completes a byte, give the byte priority: rx_valid pulses, aborted does not.
REQ-029 SHALL operate correctly for sclk half-period >= SYNC_STAGES+3 clk; slower sclk is always legal.

Reset
REQ-030 SHALL, on rst low, asynchronously force IDLE, bit_cnt=0, tx_reg=0, rx register=0, dataout=0, miso=0, miso_oe=0, tx_load=0, rx_valid=0, aborted=0, busy=0, synchronizer flops ss=1, sclk=CPOL, mosi=0.
REQ-031 SHALL, if reset releases while ss is low, remain IDLE until ss is first seen high, then low.

Structure
REQ-032 SHALL place FSM state encodings (IDLE, ACTIVE) and the SPI mode encoding in a shared spi_pkg package, also used by the master.
REQ-033 SHALL use one sub-module, spi_sync, a SYNC_STAGES-deep synchronizer instantiated per asynchronous input.

Verification
REQ-034 SHALL test mode 0 (CPOL=0, CPHA=0), datain=8'hA5, master sends 8'h3C -> master receives 8'hA5, dataout=8'h3C, exactly one rx_valid, two tx_load.
REQ-035 SHALL test mode 3 (CPOL=1, CPHA=1), three bytes 8'h01, 8'h80, 8'hFF in one frame with datain 8'h11/8'h22/8'h33 -> three rx_valid in order, master receives 8'h11, 8'h22, 8'h33.
REQ-036 SHALL test ss rise after 5 sclk cycles -> aborted pulses once, no rx_valid, dataout keeps prior value, next frame byte 8'h5A received correctly.
REQ-037 SHALL test sclk toggling while ss=1 -> no rx_valid, no tx_load, miso_oe=0 throughout.
REQ-038 SHALL test rst low mid-byte (bit_cnt=4) -> all outputs at reset values within the same clk, next full frame correct.
REQ-039 SHALL test modes 1 and 2 at minimum half-period SYNC_STAGES+3 clk -> byte 8'hC3 exchanged error-free both directions.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_pkg : FSM state and SPI mode encodings shared by SPI master and slave
// Rev 1.0
// ----------------------------------------------------------------------------
package spi_pkg;

  localparam int unsigned c_cnt_w = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  function automatic spi_mode_e spi_mode(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

  // CPHA=0 modes capture data on the leading sclk edge
  function automatic logic sample_on_leading(input spi_mode_e mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_sync : STAGES-deep single-bit synchronizer with a configurable reset value
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_slave : oversampled SPI slave, all four modes, byte framing under ss
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] datain,
  output logic       tx_load,
  output logic [7:0] dataout,
  output logic       rx_valid,
  output logic       aborted,
  output logic       busy
);

  // sclk is synchronized relative to CPOL, so a reset value of 0 means "idle level"
  logic w_sclk_norm;
  logic w_sclk_s;
  logic w_ss_s;
  logic w_mosi_s;

  assign w_sclk_norm = sclk ^ CPOL;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk),
    .rst (rst),
    .d   (w_sclk_norm),
    .q   (w_sclk_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk (clk),
    .rst (rst),
    .d   (ss),
    .q   (w_ss_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d   (mosi),
    .q   (w_mosi_s)
  );

  logic                 r_sclk_d;
  logic                 r_ss_d;
  logic [SYNC_STAGES:0] r_settle;
  logic                 r_armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_d <= 1'b0;
      r_ss_d   <= 1'b1;
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_ss_d   <= w_ss_s;
      r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
      // a frame may only start after ss has genuinely been seen high post-reset
      r_armed  <= r_armed | (r_settle[SYNC_STAGES] & w_ss_s);
    end
  end

  logic      w_lead;
  logic      w_trail;
  logic      w_lead_samples;
  logic      w_sample_edge;
  logic      w_drive_edge;
  logic      w_ss_fall;
  logic      w_ss_rise;
  spi_mode_e w_mode;

  assign w_lead         = w_sclk_s & ~r_sclk_d;
  assign w_trail        = ~w_sclk_s & r_sclk_d;
  assign w_mode         = spi_mode(CPOL, CPHA);
  assign w_lead_samples = sample_on_leading(w_mode);
  assign w_sample_edge  = w_lead_samples ? w_lead : w_trail;
  assign w_drive_edge   = w_lead_samples ? w_trail : w_lead;
  assign w_ss_fall      = r_ss_d & ~w_ss_s;
  assign w_ss_rise      = ~r_ss_d & w_ss_s;

  spi_state_e r_state;
  spi_state_e w_state_nxt;
  logic       w_enter;
  logic       w_leave;
  logic       w_sample;
  logic       w_drive;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_leave     = 1'b0;
    w_sample    = 1'b0;
    w_drive     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall && r_armed) begin
          w_state_nxt = ACTIVE;
          w_enter     = 1'b1;
        end
      end
      ACTIVE: begin
        // edges still count on the leaving clk so a just-completed byte is kept
        w_sample = w_sample_edge;
        w_drive  = w_drive_edge;
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          w_leave     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [7:0]         r_rx_sr;
  logic [7:0]         r_tx;
  logic [7:0]         r_dataout;
  logic [7:0]         w_rx_word;
  logic               r_rx_valid;
  logic               r_tx_load;
  logic               r_aborted;
  logic               w_byte_done;
  logic               w_load;

  always_comb begin
    w_cnt_nxt = r_bit_cnt;
    if (w_enter) begin
      w_cnt_nxt = '0;
    end else if (w_sample) begin
      w_cnt_nxt = r_bit_cnt + 1'b1;
    end
  end

  assign w_rx_word   = {r_rx_sr[6:0], w_mosi_s};
  assign w_byte_done = w_sample && (r_bit_cnt == '1);
  // CPHA=0 needs bit 7 on miso before the first leading edge
  assign w_load      = (w_drive && (r_bit_cnt == '0)) || (w_enter && !CPHA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt  <= '0;
      r_rx_sr    <= '0;
      r_tx       <= '0;
      r_dataout  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_rx_valid <= w_byte_done;
      r_aborted  <= w_leave && (w_cnt_nxt != '0);
      r_tx_load  <= w_load && !w_leave;

      if (w_byte_done) begin
        r_dataout <= w_rx_word;
      end

      if (w_leave) begin
        r_bit_cnt <= '0;
        r_rx_sr   <= '0;
        r_tx      <= '0;
      end else begin
        r_bit_cnt <= w_cnt_nxt;
        if (w_sample) begin
          r_rx_sr <= w_rx_word;
        end
        if (w_load) begin
          r_tx <= datain;
        end else if (w_drive) begin
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  assign miso_oe  = (r_state == ACTIVE);
  assign miso     = miso_oe & r_tx[7];
  assign busy     = (r_state == ACTIVE);
  assign dataout  = r_dataout;
  assign rx_valid = r_rx_valid;
  assign tx_load  = r_tx_load;
  assign aborted  = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_slave : directed vector bench with a behavioural SPI master
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int SYNC = 2;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       CPOL = 1'b0;
  logic       CPHA = 1'b0;
  logic       sclk = 1'b0;
  logic       ss   = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] datain;
  logic       tx_load;
  logic [7:0] dataout;
  logic       rx_valid;
  logic       aborted;
  logic       busy;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .CPOL     (CPOL),
    .CPHA     (CPHA),
    .sclk     (sclk),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .datain   (datain),
    .tx_load  (tx_load),
    .dataout  (dataout),
    .rx_valid (rx_valid),
    .aborted  (aborted),
    .busy     (busy)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] s_tx [4];
  logic [7:0] m_tx [4];
  logic [7:0] m_rx [4];
  int         tx_base = 0;
  int         tx_idx  = 0;
  int         H       = 6;

  assign datain = s_tx[(tx_idx - tx_base) & 3];

  int         n_rxv = 0, n_txl = 0, n_abt = 0, n_oe = 0;
  int         b_rxv, b_txl, b_abt, b_oe;
  logic [7:0] rx_log [256];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[n_rxv & 255] = dataout;
      n_rxv++;
    end
    if (tx_load) begin
      n_txl++;
      tx_idx++;
    end
    if (aborted) n_abt++;
    if (miso_oe) n_oe++;
  end

  typedef struct {
    logic            pol;
    logic            pha;
    int              nb;
    int              h;
    logic [2:0][7:0] mo;
    logic [2:0][7:0] so;
    int              txl;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_rxv = n_rxv;
    b_txl = n_txl;
    b_abt = n_abt;
    b_oe  = n_oe;
  endtask

  task automatic start_frame(input logic pol, input logic pha);
    CPOL = pol;
    CPHA = pha;
    sclk = pol;
    wclk(6);
    tx_base = tx_idx;
    snap();
    mosi = pha ? 1'b0 : m_tx[0][7];
    ss   = 1'b0;
    wclk(H);
  endtask

  task automatic master_bits(input int nbits);
    for (int k = 0; k < nbits; k++) begin
      int b  = k / 8;
      int i  = 7 - (k % 8);
      int kn = k + 1;
      if (!CPHA) begin
        m_rx[b][i] = miso;
        sclk = ~CPOL;
        wclk(H);
        sclk = CPOL;
        mosi = (kn / 8 < 4) ? m_tx[kn / 8][7 - (kn % 8)] : 1'b0;
        wclk(H);
      end else begin
        sclk = ~CPOL;
        mosi = m_tx[b][i];
        wclk(H);
        m_rx[b][i] = miso;
        sclk = CPOL;
        wclk(H);
      end
    end
  endtask

  task automatic end_frame();
    wclk(H);
    ss   = 1'b1;
    mosi = 1'b0;
    wclk(3 * SYNC + 10);
  endtask

  task automatic load_bytes(input vec_t v);
    for (int j = 0; j < 4; j++) begin
      m_tx[j] = (j < v.nb) ? v.mo[j] : 8'h00;
      s_tx[j] = (j < v.nb) ? v.so[j] : 8'h00;
      m_rx[j] = 8'h00;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    H = v.h;
    load_bytes(v);
    start_frame(v.pol, v.pha);
    master_bits(8 * v.nb);
    end_frame();
    check($sformatf("%s rx_valid count", tag), n_rxv - b_rxv, v.nb);
    check($sformatf("%s tx_load count", tag), n_txl - b_txl, v.txl);
    check($sformatf("%s aborted count", tag), n_abt - b_abt, 0);
    for (int j = 0; j < v.nb; j++) begin
      check($sformatf("%s master byte %0d", tag, j), m_rx[j], v.so[j]);
      check($sformatf("%s slave byte %0d", tag, j), rx_log[(b_rxv + j) & 255], v.mo[j]);
    end
    check($sformatf("%s dataout", tag), dataout, v.mo[v.nb - 1]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {miso, miso_oe, tx_load, rx_valid, aborted, busy, dataout}, 14'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pol:1'b0, pha:1'b0, nb:1, h:6, mo:{8'h00, 8'h00, 8'h3C}, so:{8'h00, 8'h00, 8'hA5}, txl:2};
    vecs[1] = '{pol:1'b1, pha:1'b1, nb:3, h:6, mo:{8'hFF, 8'h80, 8'h01}, so:{8'h33, 8'h22, 8'h11}, txl:3};
    vecs[2] = '{pol:1'b0, pha:1'b1, nb:1, h:SYNC+3, mo:{8'h00, 8'h00, 8'hC3}, so:{8'h00, 8'h00, 8'hC3}, txl:1};
    vecs[3] = '{pol:1'b1, pha:1'b0, nb:1, h:SYNC+3, mo:{8'h00, 8'h00, 8'hC3}, so:{8'h00, 8'h00, 8'hC3}, txl:2};
    vecs[4] = '{pol:1'b0, pha:1'b0, nb:2, h:8, mo:{8'h00, 8'h96, 8'h5A}, so:{8'h00, 8'hF0, 8'h69}, txl:3};
    for (int j = 0; j < 4; j++) begin
      s_tx[j] = 8'h00;
      m_tx[j] = 8'h00;
      m_rx[j] = 8'h00;
    end

    #1 rst = 1'b0;
    #1 check_reset_outputs("reset outputs at power-up");
    wclk(3);
    rst = 1'b1;
    wclk(10);

    for (int v = 0; v < 5; v++) begin
      run_vec(vecs[v], $sformatf("vec%0d", v));
    end

    // abort after 5 sclk cycles; dataout must keep 8'h96 from vec4
    H = 6;
    m_tx[0] = 8'hFF; m_tx[1] = 8'h00; s_tx[0] = 8'h00; s_tx[1] = 8'h00;
    start_frame(1'b0, 1'b0);
    master_bits(5);
    end_frame();
    check("abort aborted count", n_abt - b_abt, 1);
    check("abort rx_valid count", n_rxv - b_rxv, 0);
    check("abort dataout kept", dataout, 8'h96);
    run_vec('{pol:1'b0, pha:1'b0, nb:1, h:6, mo:{8'h00, 8'h00, 8'h5A}, so:{8'h00, 8'h00, 8'h81}, txl:2}, "post-abort");

    // sclk activity with ss high must be ignored
    snap();
    CPOL = 1'b0; CPHA = 1'b0;
    for (int k = 0; k < 16; k++) begin
      sclk = ~sclk;
      mosi = k[0];
      wclk(6);
    end
    sclk = 1'b0;
    wclk(10);
    check("idle sclk rx_valid count", n_rxv - b_rxv, 0);
    check("idle sclk tx_load count", n_txl - b_txl, 0);
    check("idle sclk miso_oe cycles", n_oe - b_oe, 0);

    // ss rise on the same clk as the completing sample edge: byte wins
    H = 6;
    m_tx[0] = 8'hB7; s_tx[0] = 8'h4E; s_tx[1] = 8'h00;
    start_frame(1'b0, 1'b1);
    master_bits(7);
    sclk = 1'b1;
    mosi = m_tx[0][0];
    wclk(H);
    sclk = 1'b0;
    ss   = 1'b1;
    wclk(20);
    check("ss race rx_valid count", n_rxv - b_rxv, 1);
    check("ss race aborted count", n_abt - b_abt, 0);
    check("ss race dataout", dataout, 8'hB7);
    check("ss race master bits 7..1", m_rx[0][7:1], 7'h27);

    // reset mid-byte at bit_cnt=4, released with ss still low
    H = 6;
    m_tx[0] = 8'h3C; s_tx[0] = 8'hA5;
    start_frame(1'b0, 1'b0);
    master_bits(4);
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset mid-byte outputs");
    wclk(3);
    snap();
    rst = 1'b1;
    wclk(20);
    for (int k = 0; k < 8; k++) begin
      sclk = ~sclk;
      wclk(6);
    end
    check("reset with ss low busy", busy, 1'b0);
    check("reset with ss low miso_oe cycles", n_oe - b_oe, 0);
    check("reset with ss low tx_load count", n_txl - b_txl, 0);
    check("reset with ss low rx_valid count", n_rxv - b_rxv, 0);
    sclk = 1'b0;
    ss   = 1'b1;
    wclk(10);
    run_vec(vecs[0], "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
